// File: rtl/cr16_pkg.sv
// Shared types and encodings for the CR16 ALU instruction sequencer.
package cr16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_EXEC2,
    S_RETIRE
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd8;
  localparam logic [3:0] ALU_NOT = 4'd9;
  localparam logic [3:0] ALU_LSH = 4'd10;

  // Immediate forms reuse the RR ext code as their major opcode.
  localparam logic [3:0] OP_RR   = 4'h0;
  localparam logic [3:0] OP_LSH  = 4'h8;
  localparam logic [3:0] EXT_AND = 4'h1;
  localparam logic [3:0] EXT_OR  = 4'h2;
  localparam logic [3:0] EXT_XOR = 4'h3;
  localparam logic [3:0] EXT_LSH = 4'h4;
  localparam logic [3:0] EXT_ADD = 4'h5;
  localparam logic [3:0] EXT_SUB = 4'h9;
  localparam logic [3:0] EXT_CMP = 4'hB;
  localparam logic [3:0] EXT_MOV = 4'hD;

  typedef struct packed {
    logic [3:0]        a_sel;
    logic [3:0]        b_sel;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic              wr;
    logic              flag_upd;
    logic              illegal;
    logic              two_pass;
  } ctrl_t;

endpackage

// File: rtl/cr16_instr_decoder.sv
// Combinational decode of one CR16 ALU instruction word into datapath controls.
module cr16_instr_decoder
  import cr16_pkg::*;
(
  input  logic [15:0] instr,
  output ctrl_t       ctrl
);

  logic [3:0] op, rd, ext, rs;
  logic [7:0] imm8;

  assign op   = instr[15:12];
  assign rd   = instr[11:8];
  assign ext  = instr[7:4];
  assign rs   = instr[3:0];
  assign imm8 = instr[7:0];

  always_comb begin
    ctrl       = '0;
    ctrl.a_sel = rd;
    if (op == OP_RR) begin
      ctrl.b_sel = rs;
      ctrl.wr    = 1'b1;
      case (ext)
        EXT_AND: ctrl.alu_op = ALU_AND;
        EXT_OR:  ctrl.alu_op = ALU_OR;
        EXT_XOR: ctrl.alu_op = ALU_XOR;
        EXT_ADD: begin ctrl.alu_op = ALU_ADD; ctrl.flag_upd = 1'b1; end
        EXT_SUB: begin ctrl.alu_op = ALU_SUB; ctrl.flag_upd = 1'b1; end
        EXT_CMP: begin ctrl.alu_op = ALU_SUB; ctrl.flag_upd = 1'b1; ctrl.wr = 1'b0; end
        EXT_MOV: begin
          // Rd = Rsrc + 0
          ctrl.a_sel   = rs;
          ctrl.b_sel   = 4'd0;
          ctrl.imm_sel = 1'b1;
          ctrl.alu_op  = ALU_ADD;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end else if (op == OP_LSH) begin
      if (ext == EXT_LSH) begin
        ctrl.b_sel  = rs;
        ctrl.alu_op = ALU_LSH;
        ctrl.wr     = 1'b1;
      end else begin
        ctrl.illegal = 1'b1;
      end
    end else begin
      ctrl.imm_sel = 1'b1;
      ctrl.wr      = 1'b1;
      case (op)
        EXT_AND: begin ctrl.alu_op = ALU_AND; ctrl.imm = {8'h00, imm8}; end
        EXT_OR:  begin ctrl.alu_op = ALU_OR;  ctrl.imm = {8'h00, imm8}; end
        EXT_XOR: begin ctrl.alu_op = ALU_XOR; ctrl.imm = {8'h00, imm8}; end
        EXT_ADD: begin ctrl.alu_op = ALU_ADD; ctrl.imm = {{8{imm8[7]}}, imm8}; ctrl.flag_upd = 1'b1; end
        EXT_SUB: begin ctrl.alu_op = ALU_SUB; ctrl.imm = {{8{imm8[7]}}, imm8}; ctrl.flag_upd = 1'b1; end
        EXT_CMP: begin
          ctrl.alu_op   = ALU_SUB;
          ctrl.imm      = {{8{imm8[7]}}, imm8};
          ctrl.flag_upd = 1'b1;
          ctrl.wr       = 1'b0;
        end
        // MOVI pass 1 clears Rd; the sequencer ORs imm8 in on pass 2.
        EXT_MOV: begin ctrl.alu_op = ALU_AND; ctrl.two_pass = 1'b1; end
        default: ctrl.illegal = 1'b1;
      endcase
    end
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/cr16_datapath_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, steps cr16_datapath through it, latches result/flags.
module cr16_datapath_sequencer
  import cr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int FLAG_WIDTH = 5
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  I_INSTR_VALID,
  input  logic [15:0]           I_INSTR,
  output logic                  O_INSTR_READY,
  input  logic                  I_STALL,
  output logic                  O_DONE,
  output logic                  O_ILLEGAL,
  output logic [DATA_WIDTH-1:0] O_RESULT,
  output logic [FLAG_WIDTH-1:0] O_FLAGS,
  output logic                  O_DP_ENABLE,
  output logic                  O_DP_NRESET,
  output logic [NUM_REGS-1:0]   O_DP_REG_WRITE_ENABLE,
  output logic [3:0]            O_DP_REG_A_SELECT,
  output logic [3:0]            O_DP_REG_B_SELECT,
  output logic                  O_DP_IMMEDIATE_SELECT,
  output logic [DATA_WIDTH-1:0] O_DP_IMMEDIATE,
  output logic [3:0]            O_DP_OPCODE,
  input  logic [DATA_WIDTH-1:0] I_DP_RESULT_BUS,
  input  logic [FLAG_WIDTH-1:0] I_DP_STATUS_FLAGS
);

  state_t      state, state_nxt;
  logic [15:0] instr_q;
  ctrl_t       dec;
  logic        accept;
  logic        writing;

  cr16_instr_decoder u_dec (
    .instr (instr_q),
    .ctrl  (dec)
  );

  assign O_INSTR_READY = (state == S_IDLE) && !I_STALL && !I_RESET;
  assign accept        = O_INSTR_READY && I_INSTR_VALID;
  assign writing       = (state == S_EXEC2) || ((state == S_EXEC) && dec.wr);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!I_STALL) begin
      case (state)
        S_IDLE:   if (I_INSTR_VALID) state_nxt = S_DECODE;
        S_DECODE: state_nxt = dec.illegal ? S_RETIRE : S_EXEC;
        S_EXEC:   state_nxt = dec.two_pass ? S_EXEC2 : S_RETIRE;
        S_EXEC2:  state_nxt = S_RETIRE;
        S_RETIRE: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Captures happen on the edge that ends an unstalled EXEC/EXEC2 cycle.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      instr_q  <= '0;
      O_RESULT <= '0;
      O_FLAGS  <= '0;
    end else begin
      if (accept) instr_q <= I_INSTR;
      if (!I_STALL && writing) O_RESULT <= I_DP_RESULT_BUS;
      if (!I_STALL && (state == S_EXEC) && dec.flag_upd) O_FLAGS <= I_DP_STATUS_FLAGS;
    end
  end

  always_comb begin
    O_DP_ENABLE           = !(I_STALL || I_RESET);
    O_DP_NRESET           = !I_RESET;
    O_DONE                = 1'b0;
    O_ILLEGAL             = 1'b0;
    O_DP_REG_WRITE_ENABLE = '0;
    O_DP_REG_A_SELECT     = '0;
    O_DP_REG_B_SELECT     = '0;
    O_DP_IMMEDIATE_SELECT = 1'b0;
    O_DP_IMMEDIATE        = '0;
    O_DP_OPCODE           = '0;
    case (state)
      S_DECODE, S_EXEC: begin
        O_DP_REG_A_SELECT     = dec.a_sel;
        O_DP_REG_B_SELECT     = dec.b_sel;
        O_DP_IMMEDIATE_SELECT = dec.imm_sel;
        O_DP_IMMEDIATE        = dec.imm;
        O_DP_OPCODE           = dec.alu_op;
      end
      S_EXEC2: begin
        O_DP_REG_A_SELECT     = dec.a_sel;
        O_DP_IMMEDIATE_SELECT = 1'b1;
        O_DP_IMMEDIATE        = {8'h00, instr_q[7:0]};
        O_DP_OPCODE           = ALU_OR;
      end
      S_RETIRE: begin
        O_DONE    = !I_STALL && !I_RESET;
        O_ILLEGAL = !I_STALL && !I_RESET && dec.illegal;
      end
      default: ;
    endcase
    if (writing && !I_STALL && !I_RESET)
      O_DP_REG_WRITE_ENABLE = {{(NUM_REGS-1){1'b0}}, 1'b1} << instr_q[11:8];
  end

endmodule

// File: tb/tb_cr16_datapath_sequencer.sv
// Sequencer driving a small behavioural register-file/ALU model; directed vector table plus corner sequences.
module tb_cr16_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] instr = '0;
  logic        stall = 1'b0;
  logic        rdy, done, ill, dp_en, dp_nrst, imm_sel;
  logic [15:0] result, imm, we, dp_res;
  logic [4:0]  flags, dp_flg;
  logic [3:0]  a_sel, b_sel, opc;

  always #5 clk = ~clk;

  cr16_datapath_sequencer dut (
    .I_CLK(clk), .I_RESET(rst), .I_INSTR_VALID(valid), .I_INSTR(instr),
    .O_INSTR_READY(rdy), .I_STALL(stall), .O_DONE(done), .O_ILLEGAL(ill),
    .O_RESULT(result), .O_FLAGS(flags), .O_DP_ENABLE(dp_en), .O_DP_NRESET(dp_nrst),
    .O_DP_REG_WRITE_ENABLE(we), .O_DP_REG_A_SELECT(a_sel), .O_DP_REG_B_SELECT(b_sel),
    .O_DP_IMMEDIATE_SELECT(imm_sel), .O_DP_IMMEDIATE(imm), .O_DP_OPCODE(opc),
    .I_DP_RESULT_BUS(dp_res), .I_DP_STATUS_FLAGS(dp_flg)
  );

  // Datapath model: flags = {2'b0, N, Z, C}; C is carry for ADD, borrow for SUB.
  logic [15:0] rf [16];
  logic [15:0] alu_a, alu_b;
  logic [16:0] wide;

  always_comb begin
    alu_a = rf[a_sel];
    alu_b = imm_sel ? imm : rf[b_sel];
    case (opc)
      4'd0:    wide = {1'b0, alu_a} + {1'b0, alu_b};
      4'd4:    wide = {1'b0, alu_a} - {1'b0, alu_b};
      4'd6:    wide = {1'b0, alu_a & alu_b};
      4'd7:    wide = {1'b0, alu_a | alu_b};
      4'd8:    wide = {1'b0, alu_a ^ alu_b};
      4'd9:    wide = {1'b0, ~alu_a};
      4'd10:   wide = {1'b0, alu_a << alu_b[3:0]};
      default: wide = '0;
    endcase
    dp_res = wide[15:0];
    dp_flg = {2'b00, wide[15], wide[15:0] == 16'h0000, wide[16]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (!dp_nrst)             rf[i] <= '0;
      else if (dp_en && we[i])  rf[i] <= dp_res;
    end
  end

  // Raw write-enable and disabled-cycle counters, snapshotted by the driver.
  int wr_cnt [16];
  int dis_cnt = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) if (we[i]) wr_cnt[i] <= wr_cnt[i] + 1;
    if (!dp_en) dis_cnt <= dis_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
    logic        ill;
    logic [15:0] wmask;
    int          wcnt;
    int          stall_lat;
    int          stall_len;
  } vec_t;

  task automatic run(input vec_t v, input int idx);
    int n, lat, dis0, wsum;
    int w0 [16];
    logic [15:0] mask;
    string tag;
    tag = $sformatf("v%0d_%h", idx, v.instr);
    @(negedge clk);
    valid = 1'b1;
    instr = v.instr;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, {31'b0, rdy}, 32'd1);
    for (int i = 0; i < 16; i++) w0[i] = wr_cnt[i];
    dis0 = dis_cnt;
    @(negedge clk);
    valid = 1'b0;
    instr = '0;
    lat = 1;
    while (!done && lat < 30) begin
      stall = (v.stall_len > 0) && (lat >= v.stall_lat) && (lat < v.stall_lat + v.stall_len);
      @(negedge clk);
      lat++;
    end
    stall = 1'b0;
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_result"}, {16'b0, result}, {16'b0, v.res});
    chk({tag, "_flags"}, {27'b0, flags}, {27'b0, v.flg});
    chk({tag, "_illegal"}, {31'b0, ill}, {31'b0, v.ill});
    chk({tag, "_retire_ctrl"}, {we, 8'b0, opc, a_sel}, 32'd0);
    mask = '0;
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_cnt[i] != w0[i]) mask[i] = 1'b1;
      wsum += wr_cnt[i] - w0[i];
    end
    chk({tag, "_wmask"}, {16'b0, mask}, {16'b0, v.wmask});
    chk({tag, "_wcount"}, wsum, v.wcnt);
    chk({tag, "_disabled"}, dis_cnt - dis0, v.stall_len);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'b0, done, ill}, 32'd0);
  endtask

  vec_t tbl [28];
  vec_t post;
  int   w0 [16];
  int   wsum, n;

  initial begin
    //           instr     res       flg    lat ill  wmask     wc sl sn
    tbl[0]  = '{16'hD105, 16'h0005, 5'h00, 4, 1'b0, 16'h0002, 2, 0, 0}; // MOVI R1,#5
    tbl[1]  = '{16'hD203, 16'h0003, 5'h00, 4, 1'b0, 16'h0004, 2, 0, 0}; // MOVI R2,#3
    tbl[2]  = '{16'h0152, 16'h0008, 5'h00, 3, 1'b0, 16'h0002, 1, 0, 0}; // ADD R1,R2
    tbl[3]  = '{16'hD000, 16'h0000, 5'h00, 4, 1'b0, 16'h0001, 2, 0, 0}; // MOVI R0,#0
    tbl[4]  = '{16'h9001, 16'hFFFF, 5'h05, 3, 1'b0, 16'h0001, 1, 0, 0}; // SUBI R0,#1
    tbl[5]  = '{16'h03D0, 16'hFFFF, 5'h05, 3, 1'b0, 16'h0008, 1, 0, 0}; // MOV R3,R0
    tbl[6]  = '{16'h06D1, 16'h0008, 5'h05, 3, 1'b0, 16'h0040, 1, 0, 0}; // MOV R6,R1
    tbl[7]  = '{16'hD407, 16'h0007, 5'h05, 4, 1'b0, 16'h0010, 2, 0, 0}; // MOVI R4,#7
    tbl[8]  = '{16'hD504, 16'h0004, 5'h05, 4, 1'b0, 16'h0020, 2, 0, 0}; // MOVI R5,#4
    tbl[9]  = '{16'h06D4, 16'h0007, 5'h05, 3, 1'b0, 16'h0040, 1, 0, 0}; // MOV R6,R4
    tbl[10] = '{16'h0615, 16'h0004, 5'h05, 3, 1'b0, 16'h0040, 1, 0, 0}; // AND R6,R5
    tbl[11] = '{16'h07D4, 16'h0007, 5'h05, 3, 1'b0, 16'h0080, 1, 0, 0}; // MOV R7,R4
    tbl[12] = '{16'h0725, 16'h0007, 5'h05, 3, 1'b0, 16'h0080, 1, 0, 0}; // OR R7,R5
    tbl[13] = '{16'h08D4, 16'h0007, 5'h05, 3, 1'b0, 16'h0100, 1, 0, 0}; // MOV R8,R4
    tbl[14] = '{16'h0835, 16'h0003, 5'h05, 3, 1'b0, 16'h0100, 1, 0, 0}; // XOR R8,R5
    tbl[15] = '{16'h04B4, 16'h0003, 5'h02, 3, 1'b0, 16'h0000, 0, 0, 0}; // CMP R4,R4
    tbl[16] = '{16'h09D4, 16'h0007, 5'h02, 3, 1'b0, 16'h0200, 1, 0, 0}; // MOV R9,R4
    tbl[17] = '{16'hF000, 16'h0007, 5'h02, 2, 1'b1, 16'h0000, 0, 0, 0}; // illegal op
    tbl[18] = '{16'h0000, 16'h0007, 5'h02, 2, 1'b1, 16'h0000, 0, 0, 0}; // illegal RR ext
    tbl[19] = '{16'h8405, 16'h0007, 5'h02, 2, 1'b1, 16'h0000, 0, 0, 0}; // LSH bad ext
    tbl[20] = '{16'h54FF, 16'h0006, 5'h01, 3, 1'b0, 16'h0010, 1, 0, 0}; // ADDI R4,#-1
    tbl[21] = '{16'h8445, 16'h0060, 5'h01, 3, 1'b0, 16'h0010, 1, 0, 0}; // LSH R4,R5
    tbl[22] = '{16'h140F, 16'h0000, 5'h01, 3, 1'b0, 16'h0010, 1, 0, 0}; // ANDI R4,#0F
    tbl[23] = '{16'h24A5, 16'h00A5, 5'h01, 3, 1'b0, 16'h0010, 1, 0, 0}; // ORI R4,#A5
    tbl[24] = '{16'h34FF, 16'h005A, 5'h01, 3, 1'b0, 16'h0010, 1, 0, 0}; // XORI R4,#FF
    tbl[25] = '{16'hB45A, 16'h005A, 5'h02, 3, 1'b0, 16'h0000, 0, 0, 0}; // CMPI R4,#5A
    tbl[26] = '{16'h0A52, 16'h0003, 5'h00, 6, 1'b0, 16'h0400, 1, 2, 3}; // ADD R10,R2, stall in EXEC
    tbl[27] = '{16'hDBBC, 16'h00BC, 5'h00, 6, 1'b0, 16'h0800, 2, 3, 2}; // MOVI R11, stall in EXEC2

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, rdy}, 32'd0);
    chk("rst_dp_pins", {29'b0, dp_nrst, dp_en, done}, 32'd0);
    chk("rst_we", {16'b0, we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, rdy}, 32'd1);
    chk("post_rst_regs", {11'b0, flags, result}, 32'd0);
    chk("idle_dp_pins", {30'b0, dp_nrst, dp_en}, 32'd3);

    for (int i = 0; i < 28; i++) run(tbl[i], i);

    // Stall while idle: ready drops and the offered instruction is not taken.
    @(negedge clk);
    stall = 1'b1;
    valid = 1'b1;
    instr = 16'hDC11;
    #1;
    chk("idle_stall_ready", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    chk("idle_stall_held", {30'b0, rdy, done}, 32'd0);
    stall = 1'b0;
    post = '{16'hDC11, 16'h0011, 5'h00, 4, 1'b0, 16'h1000, 2, 0, 0};
    run(post, 100);

    // Reset asserted in EXEC: no write, back to idle, outputs cleared.
    @(negedge clk);
    valid = 1'b1;
    instr = 16'h0DD4;
    n = 0;
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 16; i++) w0[i] = wr_cnt[i];
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("exec_we_before_rst", {16'b0, we}, 32'h2000);
    rst = 1'b1;
    #1;
    chk("exec_rst_we", {16'b0, we}, 32'd0);
    @(negedge clk);
    chk("rst_in_exec_ready", {30'b0, rdy, done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_exec_ready_after", {31'b0, rdy}, 32'd1);
    chk("rst_exec_outputs", {10'b0, ill, flags, result}, 32'd0);
    wsum = 0;
    for (int i = 0; i < 16; i++) wsum += wr_cnt[i] - w0[i];
    chk("rst_exec_no_write", wsum, 0);
    repeat (3) @(negedge clk);
    chk("rst_exec_no_done", {30'b0, done, ill}, 32'd0);
    post = '{16'hD333, 16'h0033, 5'h00, 4, 1'b0, 16'h0008, 2, 0, 0};
    run(post, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
